// File: rtl/loop_counter_pkg.sv
// Shared types and helpers for the nested-loop counter.
package loop_counter_pkg;

    typedef enum logic {
        WRAP    = 1'b0,
        ONESHOT = 1'b1
    } lc_mode_e;

    function automatic int lvl_w(input int levels);
        return (levels <= 1) ? 1 : $clog2(levels);
    endfunction

endpackage

// File: rtl/loop_counter_level.sv
// One level of the loop nest: counter, programmable terminal count and status flags.
module loop_counter_level
    import loop_counter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_max_count,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_count,
    output logic             o_start,
    output logic             o_last,
    output logic             o_end,
    output logic             o_carry_out
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_max;
    logic [WIDTH-1:0] w_max_m1;
    logic             w_end;

    assign w_max_m1    = r_max - WIDTH'(1);
    assign w_end       = (r_count == r_max);
    assign o_count     = r_count;
    assign o_start     = (r_count == '0);
    assign o_last      = (r_count == w_max_m1);
    assign o_end       = w_end;
    // A level sitting at max passes any incoming step on as carry, so max=0 is transparent.
    assign o_carry_out = i_step & w_end;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            r_max   <= '1;
        end else begin
            if (i_load) begin
                r_max <= i_max_count;
            end
            if (i_clear) begin
                r_count <= '0;
            end else if (i_step) begin
                r_count <= w_end ? '0 : r_count + WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/loop_counter.sv
// Nested-loop counter: LEVELS chained counters with carry, terminal detect, wrap/one-shot control.
module loop_counter
    import loop_counter_pkg::*;
#(
    parameter  int WIDTH  = 16,
    parameter  int LEVELS = 2,
    localparam int LVL_W  = lvl_w(LEVELS)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_clear,
    input  logic                    i_en,
    input  logic                    i_load_max,
    input  logic [LVL_W-1:0]        i_load_level,
    input  logic [WIDTH-1:0]        i_max_count,
    input  logic                    i_oneshot,
    output logic [LEVELS*WIDTH-1:0] o_counter,
    output logic [LEVELS-1:0]       o_count_start,
    output logic [LEVELS-1:0]       o_count_last,
    output logic [LEVELS-1:0]       o_count_end,
    output logic                    o_terminal,
    output logic                    o_done,
    output logic                    o_wrapped
);

    logic [LEVELS:0]   w_chain;
    logic [LEVELS-1:0] w_load;
    logic              w_terminal;
    logic              w_try;
    logic              w_hold;
    lc_mode_e          w_mode;
    logic              r_done;
    logic              r_wrapped;

    assign w_mode     = lc_mode_e'(i_oneshot);
    assign w_terminal = &o_count_end;
    assign w_try      = i_en & ~i_clear & ~i_load_max & ~r_done;
    // One-shot at terminal freezes every level instead of letting the carry wrap them.
    assign w_hold     = w_terminal & (w_mode == ONESHOT);
    assign w_chain[0] = w_try & ~w_hold;

    genvar gi;
    generate
        for (gi = 0; gi < LEVELS; gi++) begin : g_level
            assign w_load[gi] = i_load_max & (i_load_level == LVL_W'(gi));

            loop_counter_level #(
                .WIDTH(WIDTH)
            ) u_level (
                .i_clk       (i_clk),
                .i_rst       (i_rst),
                .i_clear     (i_clear),
                .i_load      (w_load[gi]),
                .i_max_count (i_max_count),
                .i_step      (w_chain[gi]),
                .o_count     (o_counter[gi*WIDTH +: WIDTH]),
                .o_start     (o_count_start[gi]),
                .o_last      (o_count_last[gi]),
                .o_end       (o_count_end[gi]),
                .o_carry_out (w_chain[gi+1])
            );
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_done    <= 1'b0;
            r_wrapped <= 1'b0;
        end else if (i_clear) begin
            r_done    <= 1'b0;
            r_wrapped <= 1'b0;
        end else begin
            if (w_try & w_hold) begin
                r_done <= 1'b1;
            end
            // Carry out of the top level only happens on a wrapping terminal advance.
            r_wrapped <= w_chain[LEVELS];
        end
    end

    assign o_terminal = w_terminal;
    assign o_done     = r_done;
    assign o_wrapped  = r_wrapped;

endmodule

// File: tb/tb_loop_counter.sv
// Directed-vector bench for loop_counter with LEVELS=2, WIDTH=8.
module tb_loop_counter;
    import loop_counter_pkg::*;

    localparam int W = 8;
    localparam int L = 2;

    logic           clk;
    logic           rst, clear, en, load_max, oneshot;
    logic [0:0]     load_level;
    logic [W-1:0]   max_count;
    logic [L*W-1:0] counter;
    logic [L-1:0]   count_start, count_last, count_end;
    logic           terminal, done, wrapped;

    loop_counter #(.WIDTH(W), .LEVELS(L)) dut (
        .i_clk(clk), .i_rst(rst), .i_clear(clear), .i_en(en),
        .i_load_max(load_max), .i_load_level(load_level), .i_max_count(max_count),
        .i_oneshot(oneshot), .o_counter(counter), .o_count_start(count_start),
        .o_count_last(count_last), .o_count_end(count_end), .o_terminal(terminal),
        .o_done(done), .o_wrapped(wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst, clr, en, ld, lvl, os;
        logic [W-1:0] mx;
        logic [W-1:0] l1, l0;
        logic         term, dn, wr;
    } vec_t;

    vec_t         vecs[$];
    int           total = 0;
    int           bad = 0;
    logic [W-1:0] m0 = '1;
    logic [W-1:0] m1 = '1;

    function automatic vec_t mk(logic r, logic c, logic e, logic ld, logic lvl, int mx, logic os,
                                int l1, int l0, logic t, logic d, logic w);
        vec_t v;
        v.rst = r; v.clr = c; v.en = e; v.ld = ld; v.lvl = lvl; v.mx = W'(mx); v.os = os;
        v.l1 = W'(l1); v.l0 = W'(l0); v.term = t; v.dn = d; v.wr = w;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d got=%0h want=%0h", name, idx, act, exp);
        end
    endtask

    task automatic run_vec(vec_t v, int idx);
        logic [W-1:0] mm1_0, mm1_1;
        rst = v.rst; clear = v.clr; en = v.en; load_max = v.ld;
        load_level = v.lvl; max_count = v.mx; oneshot = v.os;
        @(posedge clk);
        #1;
        if (v.rst) begin
            m0 = '1; m1 = '1;
        end else if (v.ld) begin
            if (v.lvl) m1 = v.mx; else m0 = v.mx;
        end
        mm1_0 = m0 - 8'd1;
        mm1_1 = m1 - 8'd1;
        chk("counter",  idx, 32'(counter), 32'({v.l1, v.l0}));
        chk("start",    idx, 32'(count_start), 32'({v.l1 == 0, v.l0 == 0}));
        chk("last",     idx, 32'(count_last), 32'({v.l1 == mm1_1, v.l0 == mm1_0}));
        chk("end",      idx, 32'(count_end), 32'({v.l1 == m1, v.l0 == m0}));
        chk("terminal", idx, 32'(terminal), 32'(v.term));
        chk("done",     idx, 32'(done), 32'(v.dn));
        chk("wrapped",  idx, 32'(wrapped), 32'(v.wr));
    endtask

    initial begin
        rst = 0; clear = 0; en = 0; load_max = 0; oneshot = 0; load_level = 0; max_count = 0;
        repeat (2) @(posedge clk);

        // reset with en high, then program max0=2, max1=1 (second load carries an ignored en)
        vecs.push_back(mk(1,0,1,0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(mk(0,0,0,1,0,2,0, 0,0, 0,0,0));
        vecs.push_back(mk(0,0,1,1,1,1,0, 0,0, 0,0,0));
        // wrap nest
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,1, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,2, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 1,0, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 1,1, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 1,2, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,0, 0,0,1));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0, 0,0,0));
        // one-shot
        vecs.push_back(mk(0,0,1,0,0,0,1, 0,1, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,1, 0,2, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,1, 1,0, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,1, 1,1, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,1, 1,2, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,1, 1,2, 1,1,0));
        vecs.push_back(mk(0,0,1,0,0,0,1, 1,2, 1,1,0));
        vecs.push_back(mk(0,1,1,0,0,0,1, 0,0, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,1, 0,1, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,1, 0,2, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,1, 1,0, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,1, 1,1, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,1, 1,2, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,1, 1,2, 1,1,0));
        vecs.push_back(mk(0,1,1,0,0,0,0, 0,0, 0,0,0));
        // load with en at (0,1): counter holds, new max0=5 takes effect
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,1, 0,0,0));
        vecs.push_back(mk(0,0,1,1,0,5,0, 0,1, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,2, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,3, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,4, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,5, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 1,0, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 1,1, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 1,2, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 1,3, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 1,4, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 1,5, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,0, 0,0,1));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,1, 0,0,0));
        // clear + load together
        vecs.push_back(mk(0,1,0,1,1,3,0, 0,0, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,1, 0,0,0));
        // degenerate max0=0, max1=3
        vecs.push_back(mk(0,1,0,1,0,0,0, 0,0, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 1,0, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 2,0, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 3,0, 1,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,0, 0,0,1));
        vecs.push_back(mk(0,0,1,0,0,0,0, 1,0, 0,0,0));
        // mid-run reset at (1,1)
        vecs.push_back(mk(0,1,0,1,0,2,0, 0,0, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,1, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,2, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 1,0, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 1,1, 0,0,0));
        vecs.push_back(mk(1,0,1,0,0,0,0, 0,0, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,1, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,2, 0,0,0));
        vecs.push_back(mk(0,0,1,0,0,0,0, 0,3, 0,0,0));

        foreach (vecs[i]) run_vec(vecs[i], i);

        // after reset the max is 255 again: l1 must hold until l0 reaches 255
        for (int k = 4; k < 255; k++) begin
            run_vec(mk(0,0,1,0,0,0,0, 0,k, 0,0,0), 1000 + k);
        end
        run_vec(mk(0,0,1,0,0,0,0, 0,255, 0,0,0), 2000);
        run_vec(mk(0,0,1,0,0,0,0, 1,0, 0,0,0), 2001);

        // shrink max0 below the count: l0 overflows to 0 with no carry, then ends at the new max
        run_vec(mk(0,0,0,0,0,0,0, 1,0, 0,0,0), 3000);
        run_vec(mk(0,0,1,0,0,0,0, 1,1, 0,0,0), 3001);
        run_vec(mk(0,0,1,0,0,0,0, 1,2, 0,0,0), 3002);
        run_vec(mk(0,0,0,1,0,1,0, 1,2, 0,0,0), 3003);
        for (int k = 3; k < 256; k++) begin
            run_vec(mk(0,0,1,0,0,0,0, 1,k, 0,0,0), 3000 + k);
        end
        run_vec(mk(0,0,1,0,0,0,0, 1,0, 0,0,0), 3300);
        run_vec(mk(0,0,1,0,0,0,0, 1,1, 0,0,0), 3301);
        run_vec(mk(0,0,1,0,0,0,0, 2,0, 0,0,0), 3302);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
